aes256_rkey_store: RTL and testbench
====================================

Name: aes256_rkey_store

Overview:
Round-key buffer that sits directly downstream of the AES-256 key expander. It captures the 15 round keys (indices 0..14) that the expander emits on its rk256/rk256_le/rk256_count strobe interface. It then streams them to the cipher datapath, one key per cycle: forward order for encryption, reverse order for decryption. The cipher core can therefore run back-to-back blocks without re-expanding the key.

Parameters:
NKEYS, 15, number of round keys stored (AES-256); index width fixed at 4 bits.

Ports:
mclk  input  1  master clock
arst_n  input  1  reset, asynchronous, active-low
start256  input  1  expander start; invalidates store and begins fill
rk256  input  128  round key from expander, bit 0 = MSB
rk256_count  input  4  index of rk256
rk256_le  input  1  rk256/rk256_count valid strobe
seq_start  input  1  request a key stream
seq_dec  input  1  sampled with seq_start: 0 = index 0..14, 1 = index 14..0
seq_hold  input  1  stall stream; hold current key and index
rk_out  output  128  streamed round key (0 when rk_out_valid=0)
rk_out_idx  output  4  index of rk_out
rk_out_valid  output  1  rk_out valid
rk_last  output  1  final key of stream on rk_out this cycle
keys_ready  output  1  all NKEYS keys captured
seq_busy  output  1  stream in progress
err_not_ready  output  1  one-cycle pulse: seq_start rejected

Behaviour:
- Reset: all outputs 0; key memory (15x128) cleared to 0; valid mask cleared to 0; fill FSM = EMPTY; stream FSM = SIDLE; pointer = 0.
- Fill FSM states and transitions:
  - EMPTY -> FILL on start256.
  - FILL -> READY on the rk256_le beat with rk256_count == NKEYS-1, once all 15 valid-mask bits are set.
  - READY -> FILL on start256.
- start256 in any state (including FILL):
  - clears the valid mask and keys_ready at the next edge;
  - aborts an active stream: stream FSM -> SIDLE, and rk_out_valid/seq_busy are 0 from the next cycle.
- Write, in FILL only: on rk256_le, mem[rk256_count] <= rk256 and valid[rk256_count] <= 1.
  - rk256_count >= NKEYS is ignored.
  - rk256_le outside FILL is ignored; the memory is unchanged.
  - A repeated index overwrites the stored key.
  - An out-of-order arrival is accepted.
- keys_ready is registered: it rises the cycle after the final write and stays 1 until start256 or reset.
- Stream FSM states: SIDLE, SRUN.
  - SIDLE -> SRUN on seq_start when keys_ready=1 and start256=0. The pointer loads 0 (seq_dec=0) or NKEYS-1 (seq_dec=1), and the direction is latched.
  - seq_start rejected (keys_ready=0, or start256 in the same cycle): err_not_ready=1 for the next cycle only; the FSM stays in SIDLE.
  - seq_start while in SRUN is ignored; no error is flagged.
- Latency: seq_start sampled at edge T gives the first key on rk_out with rk_out_valid=1 in cycle T+1. rk_out = mem[pointer] is a combinational read of the registered pointer.
- In SRUN:
  - rk_out_valid=1, seq_busy=1, rk_out_idx = pointer.
  - Each edge with seq_hold=0, the pointer moves +1 (enc) or -1 (dec).
  - seq_hold=1 freezes the pointer, so rk_out and rk_out_idx are held; rk_out_valid stays 1.
- rk_last=1 while the pointer equals the end index (14 enc, 0 dec). The first edge with seq_hold=0 in that state returns the FSM to SIDLE, and the outputs drop to 0 the following cycle.
- The pointer never wraps; there is no arithmetic beyond the 4-bit increment/decrement within 0..14.
- A new seq_start can be accepted in the cycle after the stream returns to SIDLE. Minimum gap between streams: 1 idle cycle.
- Reset asserted mid-fill or mid-stream: immediate return to the reset values listed above.

Test Plan:
- Fill then encrypt stream:
  - Stimulus: drive the FIPS-197 C.3 key 000102..1f schedule, indices 0..14 with one strobe every 2 cycles; then seq_start with seq_dec=0.
  - Response: keys_ready rises the cycle after idx 14. rk_out = 000102030405060708090a0b0c0d0e0f at idx 0, then 101112131415161718191a1b1c1d1e1f at idx 1, ending with 24fc79ccbf0979e9371ac23c6d68de36 at idx 14 with rk_last=1, over 15 consecutive valid cycles.
- Decrypt stream:
  - Stimulus: seq_dec=1 on the same store.
  - Response: first beat is idx 14 = 24fc79cc..de36; the last beat is idx 0 = 00010203..0e0f with rk_last=1.
- Not ready:
  - Stimulus: seq_start after only 7 keys have been written.
  - Response: err_not_ready=1 for exactly one cycle; rk_out_valid stays 0.
- Hold:
  - Stimulus: seq_hold=1 for 3 cycles at idx 5 during an enc stream.
  - Response: idx 5 and its key are held for 4 cycles; the stream still ends at idx 14, 18 valid cycles in total.
- Abort:
  - Stimulus: start256 at idx 9 of a stream.
  - Response: rk_out_valid=0 and keys_ready=0 next cycle; a new fill must complete before the next stream; stale keys are never streamed.
- Ignored strobes:
  - Stimulus: rk256_le with rk256_count=15, and rk256_le while in READY.
  - Response: memory and keys_ready are unchanged.

Source files
------------

// File: rtl/aes256_rkey_store.sv
// ============================================================================
// Module   : aes256_rkey_store
// Captures the 15 AES-256 round keys from the key expander and streams them
// to the cipher datapath, forward for encryption or reverse for decryption.
// Revision : 1.0
// ============================================================================
`default_nettype none

module aes256_rkey_store #(
  parameter int NKEYS = 15
) (
  input  logic         mclk,
  input  logic         arst_n,
  input  logic         start256,
  // The expander's bit 0 (MSB) arrives on bit 127.
  input  logic [127:0] rk256,
  input  logic [3:0]   rk256_count,
  input  logic         rk256_le,
  input  logic         seq_start,
  input  logic         seq_dec,
  input  logic         seq_hold,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_out_idx,
  output logic         rk_out_valid,
  output logic         rk_last,
  output logic         keys_ready,
  output logic         seq_busy,
  output logic         err_not_ready
);

  localparam logic [3:0] c_NKEYS    = 4'(NKEYS);
  localparam logic [3:0] c_LAST_IDX = 4'(NKEYS - 1);

  typedef enum logic [1:0] {EMPTY = 2'd0, FILL = 2'd1, READY = 2'd2} fill_state_t;
  typedef enum logic       {SIDLE = 1'b0, SRUN = 1'b1} seq_state_t;

  fill_state_t        r_fill, w_fill_next;
  seq_state_t         r_seq, w_seq_next;
  logic [127:0]       r_mem [NKEYS];
  logic [NKEYS-1:0]   r_valid;
  logic [NKEYS-1:0]   w_onehot;
  logic [NKEYS-1:0]   w_valid_set;
  logic               w_wr;
  logic [3:0]         r_ptr, w_ptr_next;
  logic               r_dec, w_dec_next;
  logic               r_err, w_err_next;
  logic [3:0]         w_end_idx;

  // A start256 in the same cycle wins over any strobe.
  assign w_wr        = (r_fill == FILL) && rk256_le && !start256 && (rk256_count < c_NKEYS);
  assign w_onehot    = {{(NKEYS-1){1'b0}}, 1'b1} << rk256_count;
  assign w_valid_set = r_valid | (w_wr ? w_onehot : '0);

  always_ff @(posedge mclk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < NKEYS; i++) r_mem[i] <= '0;
    end else if (w_wr) begin
      r_mem[rk256_count] <= rk256;
    end
  end

  always_ff @(posedge mclk or negedge arst_n) begin
    if (!arst_n)       r_valid <= '0;
    else if (start256) r_valid <= '0;
    else if (w_wr)     r_valid <= w_valid_set;
  end

  always_ff @(posedge mclk or negedge arst_n) begin
    if (!arst_n) r_fill <= EMPTY;
    else         r_fill <= w_fill_next;
  end

  always_comb begin
    w_fill_next = r_fill;
    if (start256)
      w_fill_next = FILL;
    else if (w_wr && (rk256_count == c_LAST_IDX) && (&w_valid_set))
      w_fill_next = READY;
  end

  assign keys_ready = (r_fill == READY);
  assign w_end_idx  = r_dec ? 4'd0 : c_LAST_IDX;

  always_ff @(posedge mclk or negedge arst_n) begin
    if (!arst_n) begin
      r_seq <= SIDLE;
      r_ptr <= '0;
      r_dec <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_seq <= w_seq_next;
      r_ptr <= w_ptr_next;
      r_dec <= w_dec_next;
      r_err <= w_err_next;
    end
  end

  always_comb begin
    w_seq_next = r_seq;
    w_ptr_next = r_ptr;
    w_dec_next = r_dec;
    w_err_next = 1'b0;
    case (r_seq)
      SIDLE: begin
        if (seq_start) begin
          if (keys_ready && !start256) begin
            w_seq_next = SRUN;
            w_dec_next = seq_dec;
            w_ptr_next = seq_dec ? c_LAST_IDX : 4'd0;
          end else begin
            w_err_next = 1'b1;
          end
        end
      end
      SRUN: begin
        if (start256) begin
          w_seq_next = SIDLE;
        end else if (!seq_hold) begin
          if (r_ptr == w_end_idx) w_seq_next = SIDLE;
          else                    w_ptr_next = r_dec ? (r_ptr - 4'd1) : (r_ptr + 4'd1);
        end
      end
      default: w_seq_next = SIDLE;
    endcase
  end

  always_comb begin
    rk_out_valid  = (r_seq == SRUN);
    seq_busy      = (r_seq == SRUN);
    rk_out        = (r_seq == SRUN) ? r_mem[r_ptr] : '0;
    rk_out_idx    = (r_seq == SRUN) ? r_ptr : 4'd0;
    rk_last       = (r_seq == SRUN) && (r_ptr == w_end_idx);
    err_not_ready = r_err;
  end

endmodule

`default_nettype wire

// File: tb/tb_aes256_rkey_store.sv
// ============================================================================
// Module   : tb_aes256_rkey_store
// Scoreboard bench for aes256_rkey_store: directed fills and key streams.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_aes256_rkey_store;

  localparam int NK = 15;

  logic         mclk = 1'b0;
  logic         arst_n = 1'b0;
  logic         start256 = 1'b0;
  logic [127:0] rk256 = '0;
  logic [3:0]   rk256_count = '0;
  logic         rk256_le = 1'b0;
  logic         seq_start = 1'b0;
  logic         seq_dec = 1'b0;
  logic         seq_hold = 1'b0;
  logic [127:0] rk_out;
  logic [3:0]   rk_out_idx;
  logic         rk_out_valid, rk_last, keys_ready, seq_busy, err_not_ready;

  aes256_rkey_store #(.NKEYS(NK)) dut (
    .mclk(mclk), .arst_n(arst_n), .start256(start256), .rk256(rk256),
    .rk256_count(rk256_count), .rk256_le(rk256_le), .seq_start(seq_start),
    .seq_dec(seq_dec), .seq_hold(seq_hold), .rk_out(rk_out), .rk_out_idx(rk_out_idx),
    .rk_out_valid(rk_out_valid), .rk_last(rk_last), .keys_ready(keys_ready),
    .seq_busy(seq_busy), .err_not_ready(err_not_ready)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    bit           err;
    logic [3:0]   idx;
    logic [127:0] key;
    logic         last;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  logic [127:0] key_a [NK];
  logic [127:0] key_b [NK];

  // Monitor: every presented beat or error pulse must match the next expectation.
  always @(negedge mclk) begin
    exp_t e;
    if (arst_n && (rk_out_valid || err_not_ready)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output valid=%0b err=%0b idx=%0d key=%h", rk_out_valid, err_not_ready, rk_out_idx, rk_out);
      end else begin
        e = q.pop_front();
        if (e.err) begin
          if (!(err_not_ready && !rk_out_valid)) begin
            errors++;
            $display("FAIL err_pulse got err=%0b valid=%0b required err=1 valid=0", err_not_ready, rk_out_valid);
          end
        end else if (!(rk_out_valid && !err_not_ready && rk_out_idx == e.idx && rk_out == e.key && rk_last == e.last && seq_busy)) begin
          errors++;
          $display("FAIL beat got idx=%0d key=%h last=%0b err=%0b busy=%0b required idx=%0d key=%h last=%0b",
                   rk_out_idx, rk_out, rk_last, err_not_ready, seq_busy, e.idx, e.key, e.last);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge mclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  task automatic push_beat(input int idx, input logic [127:0] key, input logic last);
    exp_t e;
    e.err = 1'b0; e.idx = 4'(idx); e.key = key; e.last = last;
    q.push_back(e);
  endtask

  task automatic push_err;
    exp_t e;
    e.err = 1'b1; e.idx = '0; e.key = '0; e.last = 1'b0;
    q.push_back(e);
  endtask

  task automatic strobe(input int idx, input logic [127:0] key);
    rk256_le = 1'b1; rk256_count = 4'(idx); rk256 = key;
    tick;
    rk256_le = 1'b0; rk256 = '0;
    tick;
  endtask

  // One strobe every 2 cycles; keys_ready must rise only after index NK-1.
  task automatic fill(input int lo, input int hi, input bit alt);
    for (int i = lo; i <= hi; i++) begin
      strobe(i, alt ? key_b[i] : key_a[i]);
      chk($sformatf("keys_ready_after_idx%0d", i), {127'd0, keys_ready}, {127'd0, i == NK-1});
    end
  endtask

  task automatic seq_reject;
    push_err();
    seq_start = 1'b1;
    tick;
    seq_start = 1'b0;
    tick;
    tick;
  endtask

  task automatic run_stream(input bit dec, input int hold_idx, input int hold_n,
                            input int abort_idx, input bit by_reset, input bit alt);
    int idx;
    int reps;
    seq_start = 1'b1; seq_dec = dec;
    tick;
    seq_start = 1'b0; seq_dec = 1'b0;
    for (int pos = 0; pos < NK; pos++) begin
      idx  = dec ? NK-1-pos : pos;
      reps = (idx == hold_idx) ? hold_n + 1 : 1;
      for (int r = 0; r < reps; r++) begin
        if (idx == abort_idx && by_reset) begin
          arst_n = 1'b0;
          return;
        end
        push_beat(idx, alt ? key_b[idx] : key_a[idx], pos == NK-1);
        if (idx == abort_idx) begin
          start256 = 1'b1;
          tick;
          start256 = 1'b0;
          return;
        end
        seq_hold = (r < reps - 1);
        tick;
      end
      seq_hold = 1'b0;
    end
    chk("idle_after_stream", {126'd0, rk_out_valid, seq_busy}, 128'd0);
  endtask

  initial begin
    key_a[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    key_a[1]  = 128'h101112131415161718191a1b1c1d1e1f;
    key_a[2]  = 128'ha573c29fa176c498a97fce93a572c09c;
    key_a[3]  = 128'h1651a8cd0244beda1a5da4c10640bade;
    key_a[4]  = 128'hae87dff00ff11b68a68ed5fb03fc1567;
    key_a[5]  = 128'h6de1f1486fa54f9275f8eb5373b8518d;
    key_a[6]  = 128'hc656827fc9a799176f294cec6cd5598b;
    key_a[7]  = 128'h3de23a75524775e727bf9eb45407cf39;
    key_a[8]  = 128'h0bdc905fc27b0948ad5245a4c1871c2f;
    key_a[9]  = 128'h45f5a66017b2d387300d4d33640a820a;
    key_a[10] = 128'h7ccff71cbeb4fe5413e6bbf0d261a7df;
    key_a[11] = 128'hf01afafee7a82979d7a5644ab3afe640;
    key_a[12] = 128'h2541fe719bf500258813bbd55a721c0a;
    key_a[13] = 128'h4e5a6699a9f24fe07e572baacdf8cdea;
    key_a[14] = 128'h24fc79ccbf0979e9371ac23c6d68de36;
    for (int i = 0; i < NK; i++) key_b[i] = key_a[i] ^ {8{16'ha5c3}};

    // Reset state
    #1;
    chk("reset_outputs", {rk_out[127:8], rk_out_idx, rk_out_valid, rk_last, keys_ready, seq_busy},
        128'd0);
    chk("reset_err_and_key", {err_not_ready, rk_out[7:0]}, 128'd0);
    tick;
    arst_n = 1'b1;
    tick;

    // Fill C.3 schedule, then encrypt followed immediately by decrypt
    start256 = 1'b1; tick; start256 = 1'b0;
    fill(0, NK-1, 1'b0);
    run_stream(1'b0, -1, 0, -1, 1'b0, 1'b0);
    run_stream(1'b1, -1, 0, -1, 1'b0, 1'b0);
    tick;

    // Ignored strobes: out-of-range index, and any strobe while READY
    strobe(15, {8{16'hdead}});
    strobe(2, {8{16'hbeef}});
    chk("keys_ready_after_ignored", {127'd0, keys_ready}, 128'd1);

    // Hold at idx 5 for 3 cycles: 18 beats, memory still intact
    run_stream(1'b0, 5, 3, -1, 1'b0, 1'b0);
    tick;

    // Abort at idx 9 via start256
    run_stream(1'b0, -1, 0, 9, 1'b0, 1'b0);
    chk("abort_outputs", {125'd0, rk_out_valid, seq_busy, keys_ready}, 128'd0);
    seq_reject();

    // Partial refill with a repeated index and an out-of-range strobe
    strobe(3, {8{16'h1234}});
    fill(0, 6, 1'b1);
    strobe(15, {8{16'h0f0f}});
    seq_reject();
    fill(7, NK-1, 1'b1);
    run_stream(1'b1, -1, 0, -1, 1'b0, 1'b1);
    tick;

    // start256 in the same cycle as seq_start is rejected
    push_err();
    seq_start = 1'b1; start256 = 1'b1;
    tick;
    seq_start = 1'b0; start256 = 1'b0;
    tick;
    chk("keys_ready_after_restart", {127'd0, keys_ready}, 128'd0);
    fill(0, NK-1, 1'b1);

    // Reset mid-stream
    run_stream(1'b0, -1, 0, 3, 1'b1, 1'b1);
    #1;
    chk("midstream_reset", {rk_out[127:4], rk_out_valid, keys_ready, seq_busy, err_not_ready}, 128'd0);
    chk("midstream_reset_idx", {124'd0, rk_out_idx}, 128'd0);
    tick;
    arst_n = 1'b1;
    tick;
    seq_reject();

    repeat (4) tick;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
